// File: rtl/fifo2_wr_arb_if.sv
// Write-side bundle between the requesters, the arbiter and the FIFO write port.
// The master modport is the environment (requesters plus FIFO); the slave modport is the arbiter.
interface fifo2_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic                    wfull;
  logic [DSIZE-1:0]        fifo_wdata;
  logic                    fifo_winc;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] owner;

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, fifo_wdata, fifo_winc, busy, owner
  );

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, fifo_wdata, fifo_winc, busy, owner
  );
endinterface

// File: rtl/fifo2_wr_arb.sv
// Round-robin, burst-locking arbiter that shares the async FIFO write port between NREQ requesters.
// Lives entirely in the write clock domain; wfull gates every beat combinationally.
module fifo2_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic          wclk,
  input  logic          wrst_n,
  fifo2_wr_arb_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] next_ptr;
  logic [OW-1:0] pick;
  logic [OW:0]   idx;
  logic [CW-1:0] beat_cnt;
  logic          busy_q;
  logic          any_valid;
  logic          xfer;
  logic          burst_end;

  // Scan downward so the requester closest to rr_ptr (in wrap order) is the last to overwrite pick.
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NREQ)) idx = idx - (OW+1)'(NREQ);
      if (bus.req_valid[idx[OW-1:0]]) pick = idx[OW-1:0];
    end
  end

  assign any_valid = |bus.req_valid;
  assign xfer      = (state == BURST) && bus.req_valid[owner_q] && !bus.wfull;
  assign burst_end = xfer && (bus.req_last[owner_q] || (beat_cnt == CNT_LAST));
  assign next_ptr  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (state == BURST) bus.req_ready[owner_q] = !bus.wfull;
  end

  assign bus.fifo_winc  = xfer;
  assign bus.fifo_wdata = bus.req_data[int'(owner_q) * DSIZE +: DSIZE];
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_q  <= '0;
      beat_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner_q  <= pick;
            beat_cnt <= '0;
            state    <= BURST;
            busy_q   <= 1'b1;
          end
        end
        BURST: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          // A stalled last beat (wfull or owner not valid) keeps the lock.
          if (burst_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo2_wr_arb.sv
// Bench for fifo2_wr_arb: per-requester beat queues drive the arbiter, and a packet-level
// reference model checks every output each cycle; directed scenarios pin literal write orders.
module tb_fifo2_wr_arb;
  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;
  localparam int DEPTH    = 64;

  logic wclk;
  logic wrst_n;

  fifo2_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo2_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {int cyc; int own; int data;} wr_t;

  // Requester beat queues: {last, data}; hd advances only on a modelled transfer.
  logic [8:0] mem [NREQ][DEPTH];
  int hd [NREQ];
  int tl [NREQ];
  int hold [NREQ];
  int stall_pct;
  bit full_rand;
  logic full_val;
  logic rst_val;

  // Reference model state: packet-level view of who holds the write port.
  bit m_busy;
  int m_own, m_ptr, m_cnt;

  wr_t wlog[$];
  int cyc, n_wr;
  int errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] dat, input logic lst);
    mem[i][tl[i] % DEPTH] = {lst, dat};
    tl[i]++;
  endtask

  task automatic drive();
    logic [NREQ-1:0]       v, l;
    logic [NREQ*DSIZE-1:0] d;
    logic [8:0]            h;
    v = '0; l = '0; d = '0;
    wrst_n = rst_val;
    for (int i = 0; i < NREQ; i++) begin
      h = mem[i][hd[i] % DEPTH];
      if (tl[i] != hd[i]) begin
        v[i] = 1'b1;
        d[i*DSIZE +: DSIZE] = h[7:0];
        l[i] = h[8];
        if (hold[i] > 0) begin
          v[i] = 1'b0;
          hold[i]--;
        end else if (int'($urandom_range(0, 99)) < stall_pct) begin
          v[i] = 1'b0;
        end
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.wfull     = full_rand ? ($urandom_range(0, 99) < 30) : full_val;
  endtask

  task automatic compare();
    logic [NREQ-1:0] exp_ready;
    logic            exp_winc;
    logic [8:0]      h;
    bit              found;
    int              j;
    cyc++;
    if (!wrst_n) begin
      m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
      chk("rst_busy",  32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_winc",  32'(bus.fifo_winc), 0);
      chk("rst_owner", 32'(bus.owner), 0);
      return;
    end
    exp_ready = '0;
    exp_winc  = 1'b0;
    if (m_busy) begin
      exp_ready[m_own] = !bus.wfull;
      exp_winc = bus.req_valid[m_own] && !bus.wfull;
    end
    h = mem[m_own][hd[m_own] % DEPTH];
    chk("busy",  32'(bus.busy), 32'(m_busy));
    chk("owner", 32'(bus.owner), m_own);
    chk("ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("winc",  32'(bus.fifo_winc), 32'(exp_winc));
    if (exp_winc) chk("wdata", 32'(bus.fifo_wdata), 32'(h[7:0]));
    if (bus.fifo_winc) begin
      wlog.push_back('{cyc, int'(bus.owner), int'(bus.fifo_wdata)});
      n_wr++;
    end
    if (m_busy) begin
      if (exp_winc) begin
        hd[m_own]++;
        m_cnt++;
        if (h[8] || m_cnt == MAXBURST) begin
          m_busy = 0;
          m_ptr  = (m_own + 1) % NREQ;
        end
      end
    end else if (bus.req_valid != '0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!found && bus.req_valid[j]) begin
          m_own = j;
          found = 1;
        end
      end
      m_busy = 1;
      m_cnt  = 0;
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
    drive();
    @(negedge wclk);
    compare();
  endtask

  task automatic do_reset();
    rst_val = 1'b0;
    tick();
    tick();
    rst_val = 1'b1;
    tick();
    wlog.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (wlog.size() < n && b > 0) begin
      tick();
      b--;
    end
    chk(name, wlog.size(), n);
  endtask

  task automatic expect_log(input string name, input int k, input int own, input int data);
    if (k < wlog.size()) begin
      chk({name, "_own"},  wlog[k].own, own);
      chk({name, "_data"}, wlog[k].data, data);
    end
  endtask

  initial begin
    int t0, pend, budget, n_push, wr0, len;
    errors = 0; checks = 0; cyc = 0; n_wr = 0;
    stall_pct = 0; full_rand = 0; full_val = 1'b0; rst_val = 1'b0;
    m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0; tl[i] = 0; hold[i] = 0;
    end
    wrst_n = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.wfull = 1'b0;
    do_reset();

    // Single requester, 3-beat packet: one idle bubble, then three back-to-back writes.
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    tick();
    t0 = cyc;
    wait_writes(3, 20, "t1_timeout");
    for (int k = 0; k < 3; k++) expect_log("t1", k, 2, 8'hA1 + k);
    if (wlog.size() >= 3) begin
      chk("t1_latency", wlog[0].cyc, t0 + 1);
      chk("t1_back2back", wlog[2].cyc - wlog[0].cyc, 2);
    end
    tick();
    chk("t1_idle_after", 32'(bus.busy), 0);

    // Round robin with four single-beat requesters.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NREQ; i++) push(i, 8'(8'h10 * i + p), 1'b1);
    wait_writes(12, 60, "t2_timeout");
    for (int k = 0; k < 12; k++) begin
      expect_log("t2", k, k % 4, 8'h10 * (k % 4) + k / 4);
      if (k > 0 && k < wlog.size()) chk("t2_gap", wlog[k].cyc - wlog[k-1].cyc, 2);
    end

    // Burst cap: 6-beat packet from requester 1 is split around requester 2.
    do_reset();
    for (int b = 0; b < 6; b++) push(1, 8'(8'h31 + b), b == 5);
    push(2, 8'h41, 1'b1);
    wait_writes(7, 40, "t3_timeout");
    expect_log("t3", 0, 1, 8'h31); expect_log("t3", 1, 1, 8'h32);
    expect_log("t3", 2, 1, 8'h33); expect_log("t3", 3, 1, 8'h34);
    expect_log("t3", 4, 2, 8'h41);
    expect_log("t3", 5, 1, 8'h35); expect_log("t3", 6, 1, 8'h36);

    // Backpressure for 3 cycles after the second beat.
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 8'(8'h51 + b), b == 3);
    wait_writes(2, 20, "t4_pre_timeout");
    full_val = 1'b1;
    tick();
    chk("t4_stall_winc",  32'(bus.fifo_winc), 0);
    chk("t4_stall_ready", 32'(bus.req_ready), 0);
    chk("t4_stall_busy",  32'(bus.busy), 1);
    tick();
    tick();
    full_val = 1'b0;
    wait_writes(4, 20, "t4_timeout");
    for (int k = 0; k < 4; k++) expect_log("t4", k, 0, 8'h51 + k);
    if (wlog.size() >= 3) chk("t4_gap", wlog[2].cyc - wlog[1].cyc, 4);

    // Owner stall: requester 0 drops valid for 2 cycles while requester 3 waits.
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 8'(8'h61 + b), b == 3);
    push(3, 8'h71, 1'b1);
    wait_writes(2, 20, "t5_pre_timeout");
    hold[0] = 2;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("t5_busy",   32'(bus.busy), 1);
      chk("t5_ready3", 32'(bus.req_ready[3]), 0);
      chk("t5_owner",  32'(bus.owner), 0);
    end
    wait_writes(5, 20, "t5_timeout");
    for (int k = 0; k < 4; k++) expect_log("t5", k, 0, 8'h61 + k);
    expect_log("t5", 4, 3, 8'h71);
    if (wlog.size() >= 3) chk("t5_gap", wlog[2].cyc - wlog[1].cyc, 3);

    // Reset during beat 2 of requester 3's burst; requester 0 wins afterwards.
    do_reset();
    for (int b = 0; b < 4; b++) push(3, 8'(8'h81 + b), b == 3);
    wait_writes(1, 20, "t6_pre_timeout");
    rst_val = 1'b0;
    tick();
    chk("t6_rst_winc", 32'(bus.fifo_winc), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    tick();
    push(0, 8'h91, 1'b1);
    rst_val = 1'b1;
    wlog.delete();
    wait_writes(4, 30, "t6_timeout");
    expect_log("t6", 0, 0, 8'h91);
    for (int k = 1; k < 4; k++) expect_log("t6", k, 3, 8'h81 + k);

    // Randomized traffic with random valid drops and random wfull.
    do_reset();
    n_push = 0;
    wr0 = n_wr;
    stall_pct = 20;
    full_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tl[i] - hd[i] < 4 && $urandom_range(0, 3) == 0) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
          n_push += len;
        end
      end
      tick();
    end
    stall_pct = 0;
    full_rand = 0;
    full_val  = 1'b0;
    budget = 400;
    pend = 1;
    while (pend != 0 && budget > 0) begin
      tick();
      budget--;
      pend = 0;
      for (int i = 0; i < NREQ; i++) if (tl[i] != hd[i]) pend++;
      if (bus.busy) pend++;
    end
    chk("rand_drain", pend, 0);
    chk("rand_count", n_wr - wr0, n_push);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo2_wr_arb.md
# fifo2_wr_arb

Write-side arbiter for the asynchronous FIFO, placed entirely in the write clock domain. It shares the FIFO write port between NREQ requesters with round-robin arbitration and burst locking, so one requester's packet (up to MAXBURST beats) lands contiguously in the FIFO. It honours `wfull` backpressure beat by beat and never asserts the FIFO write strobe while the FIFO is full.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DSIZE`, 8: data width; must equal the FIFO `DSIZE`.
- `MAXBURST`, 4: maximum beats per grant, 1..16.

- `wclk`  in  1  write-domain clock; the only clock in the block.
- `wrst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  bit i: requester i presents a beat.
- `req_data`  in  NREQ*DSIZE  beat data; requester i occupies bits [i*DSIZE +: DSIZE].
- `req_last`  in  NREQ  bit i: the current beat is the last beat of requester i's packet.
- `req_ready`  out  NREQ  bit i: the beat of requester i is accepted this cycle.
- `wfull`  in  1  full flag from the FIFO.
- `fifo_wdata`  out  DSIZE  drives the FIFO `wdata`.
- `fifo_winc`  out  1  drives the FIFO `winc`.
- `busy`  out  1  a burst is in progress (state BURST).
- `owner`  out  clog2(NREQ)  index of the current or most recent grantee.

## Operation
- A beat transfers on any `wclk` edge where `req_valid[i]` and `req_ready[i]` are both high.
- State machine (registered):
  - IDLE:
    - If any `req_valid` bit is high, pick the first requester with valid set, searching upward from `rr_ptr` and wrapping modulo NREQ.
    - Register that index into `owner`, clear `beat_cnt`, go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - `req_ready[owner] = !wfull`. All other `req_ready` bits are 0.
    - `fifo_winc = req_valid[owner] & !wfull`.
    - `fifo_wdata = req_data[owner]`.
    - On each transferred beat, `beat_cnt` increments.
    - The burst ends on the transferred beat where `req_last[owner]` is 1 or `beat_cnt == MAXBURST-1`.
    - At burst end: go to IDLE, and set `rr_ptr = (owner+1) mod NREQ`.
- While the owner holds `req_valid` low mid-burst, the lock is kept: no beat transfers and the state stays BURST. There is no timeout.
- In IDLE:
  - `req_ready` is all zeros.
  - `fifo_winc` is 0.
  - `fifo_wdata = req_data[owner]`. This value is a don't-care.
- Requesters must hold `req_data` and `req_last` stable while valid is high and ready is low.
- `busy` is 1 exactly when the state is BURST.
- `beat_cnt` width is clog2(MAXBURST+1). It is compared unsigned.

## Timing
- Reset, asynchronous, all values take effect immediately on `wrst_n` low:
  - state = IDLE, `rr_ptr` = 0, `owner` = 0, `beat_cnt` = 0.
  - `busy` = 0, `req_ready` = 0, `fifo_winc` = 0.
- Reset asserted mid-burst abandons the burst. No further `fifo_winc` is issued. After release, requester 0 has highest priority.
- Arbitration latency: valid seen in IDLE in cycle n → `req_ready` can be high in cycle n+1 (if `!wfull`). There is exactly one idle bubble cycle between consecutive bursts.
- `fifo_winc`, `fifo_wdata` and `req_ready` are combinational from registered state and the current `wfull`/`req_valid` inputs. There is no extra pipeline delay, so a `wfull` that rises in cycle n blocks the write in cycle n itself.
- The burst-end beat and a `wfull` stall in the same cycle: no transfer happens, and the burst does not end.
- A single-beat packet (`req_last` high on the first beat) occupies BURST for one cycle when not stalled.

## Test plan
- Single requester: `req_valid[2]=1`, 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), `wfull=0` → IDLE 1 cycle, then `fifo_winc` high for 3 consecutive cycles with data A1,A2,A3, `owner=2`, then IDLE.
- Round-robin fairness: all four requesters continuously valid with 1-beat packets after reset → grant order 0,1,2,3,0,1,…, one beat per 2 cycles.
- Burst cap: requester 1 sends 6 beats with no `req_last`, MAXBURST=4 → 4 beats transfer, the arbiter passes to requester 2 if it is valid, and requester 1's remaining 2 beats are granted on its next turn.
- Backpressure: `wfull` held high for 3 cycles mid-burst → `fifo_winc=0` and `req_ready=0` throughout, data held, `beat_cnt` unchanged; the burst resumes when `wfull` falls, with no lost or duplicated beat.
- Owner stall: owner drops `req_valid` for 2 cycles mid-packet while requester 3 is valid → requester 3 stays ungranted, `busy=1`; the burst completes when the owner resumes.
- Reset mid-burst: `wrst_n` pulsed low during beat 2 of 4 → all outputs 0 immediately; after release with requesters 0 and 3 both valid, requester 0 is granted first.
